// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter_if : IF/LSU requester ports plus core memory bus signals    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ack;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;

  logic                lsu_req;
  logic                lsu_w_en;
  logic [ADDR_W-1:0]   lsu_addr;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_sel;
  logic                lsu_flush;
  logic                lsu_ack;
  logic                lsu_err;
  logic [DATA_W-1:0]   lsu_rdata;

  logic                mem_req;
  logic                mem_w_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_sel;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_ack, if_err, if_rdata,
    input  lsu_req, lsu_w_en, lsu_addr, lsu_wdata, lsu_sel, lsu_flush,
    output lsu_ack, lsu_err, lsu_rdata,
    output mem_req, mem_w_en, mem_addr, mem_wdata, mem_sel,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_ack, if_err, if_rdata,
    output lsu_req, lsu_w_en, lsu_addr, lsu_wdata, lsu_sel, lsu_flush,
    input  lsu_ack, lsu_err, lsu_rdata,
    input  mem_req, mem_w_en, mem_addr, mem_wdata, mem_sel,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter : shares the core memory bus between fetch and LSU ports    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_LSU_RUN = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int SEL_W = DATA_W / 8;
  localparam int RUN_W = $clog2(MAX_LSU_RUN + 1);
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_LSU_RUN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_LSU = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               mem_w_en_q, mem_w_en_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [SEL_W-1:0]   mem_sel_q, mem_sel_d;

  logic w_if_live, w_lsu_live, w_lsu_flush_ld, w_tmo_hit;
  logic w_grant_if, w_grant_lsu;
  logic w_if_ack, w_if_err, w_lsu_ack, w_lsu_err;

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    mem_w_en_d  = mem_w_en_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    w_grant_if  = 1'b0;
    w_grant_lsu = 1'b0;
    w_if_ack    = 1'b0;
    w_if_err    = 1'b0;
    w_lsu_ack   = 1'b0;
    w_lsu_err   = 1'b0;

    w_if_live      = bus.if_req & ~bus.if_flush;
    w_lsu_live     = bus.lsu_req & ~(~bus.lsu_w_en & bus.lsu_flush);
    w_lsu_flush_ld = bus.lsu_flush & ~mem_w_en_q;
    w_tmo_hit      = (TIMEOUT > 0) && (tmo_cnt_q == TMO_LAST) && !bus.mem_ack;

    case (state_q)
      IDLE: begin
        // A pending fetch caps the LSU run so fetch is never starved
        if (w_lsu_live && !(w_if_live && run_cnt_q == RUN_MAX)) begin
          w_grant_lsu = 1'b1;
          mem_w_en_d  = bus.lsu_w_en;
          mem_addr_d  = bus.lsu_addr;
          mem_wdata_d = bus.lsu_wdata;
          mem_sel_d   = bus.lsu_sel;
          tmo_cnt_d   = '0;
          state_d     = BUSY_LSU;
        end else if (w_if_live) begin
          w_grant_if  = 1'b1;
          mem_w_en_d  = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_sel_d   = '1;
          tmo_cnt_d   = '0;
          state_d     = BUSY_IF;
        end
      end
      BUSY_IF: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bus.mem_ack || w_tmo_hit) begin
          w_if_ack = ~bus.if_flush;
          w_if_err = ~bus.if_flush & w_tmo_hit;
          state_d  = IDLE;
        end else if (bus.if_flush) begin
          tmo_cnt_d = '0;
          state_d   = DRAIN;
        end
      end
      BUSY_LSU: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bus.mem_ack || w_tmo_hit) begin
          w_lsu_ack = ~w_lsu_flush_ld;
          w_lsu_err = ~w_lsu_flush_ld & w_tmo_hit;
          state_d   = IDLE;
        end else if (w_lsu_flush_ld) begin
          tmo_cnt_d = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bus.mem_ack || w_tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!bus.if_req || w_grant_if) begin
      run_cnt_d = '0;
    end else if (w_grant_lsu && run_cnt_q < RUN_MAX) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      mem_w_en_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_w_en_q  <= mem_w_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
    end
  end

  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_w_en  = mem_w_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_sel   = mem_sel_q;

  assign bus.if_ack    = w_if_ack;
  assign bus.if_err    = w_if_err;
  assign bus.if_rdata  = (w_if_ack & ~w_if_err) ? bus.mem_rdata : '0;
  assign bus.lsu_ack   = w_lsu_ack;
  assign bus.lsu_err   = w_lsu_err;
  assign bus.lsu_rdata = (w_lsu_ack & ~w_lsu_err) ? bus.mem_rdata : '0;
endmodule
`default_nettype wire
